generic_flash_access_nios2_cpu_mult_seq: RTL and testbench
==========================================================

// Module: generic_flash_access_nios2_cpu_mult_seq
// PURPOSE
//   Two-requester sequencer for the 3-cell 16x16 partial-product multiplier (p1=a_lo*b_lo,
//   p2=a_lo*b_hi, p3=a_hi*b_lo).
//   - Arbitrates requesters round-robin.
//   - Drives operands and enable into the cell, waits out the cell latency.
//   - Combines the partials into the low 32 bits of a*b (the MUL result; identical for signed and unsigned).
//   - Returns the result to the winning requester over a valid/ready response channel.
// PARAMETERS
//   MUL_LATENCY  1   enabled clock edges from operand presentation to valid p1..p3 (legal 1..4)
//   CNT_W        16  width of completed-operation counter
// PORTS
//   clk            in   1      clock; all state on rising edge
//   reset          in   1      asynchronous, active-high reset
//   req_valid      in   2      per-requester operation request
//   req_ready      out  2      per-requester accept; at most one bit set
//   req_a          in   2x32   operand A per requester (packed, [31:0]=req0)
//   req_b          in   2x32   operand B per requester (packed, [31:0]=req0)
//   rsp_valid      out  2      result valid toward owning requester; at most one bit set
//   rsp_ready      in   2      per-requester result accept
//   rsp_data       out  32     low 32 bits of A*B
//   mul_src1       out  32     operand A to multiplier cell
//   mul_src2       out  32     operand B to multiplier cell
//   mul_en         out  1      multiplier cell register enable
//   mul_p1/p2/p3   in   32     partial products from cell
//   busy           out  1      high in any state other than IDLE
//   ops_done       out  CNT_W  completed-response count, wraps modulo 2^CNT_W
// BEHAVIOUR
//   Reset values: all outputs 0; state=IDLE; operand/result regs 0; rr pointer=0 (req0 favoured).
//   FSM states: IDLE -> ISSUE -> WAIT -> COMBINE -> RESP -> IDLE.
//   IDLE: req_ready combinational, one-hot to the arbitration winner.
//     - Winner is the requester with req_valid, searching from the one after the last grant.
//     - On req_valid&req_ready: capture A, B and owner id; move rr pointer to owner; go to ISSUE.
//   ISSUE: mul_src1/2 = captured A/B, mul_en=1; cnt loaded with MUL_LATENCY-1.
//     - MUL_LATENCY=1: go straight to COMBINE. Otherwise go to WAIT.
//   WAIT: operands held, mul_en=1; decrement cnt; go to COMBINE when cnt reaches 0.
//   COMBINE: mul_en=0; register rsp_data = p1 + ((p2 + p3) << 16), modulo 2^32.
//     - Carries above bit 31 are discarded.
//     - Only the low 16 bits of (p2+p3) contribute.
//   RESP: rsp_valid[owner]=1; rsp_data held stable while rsp_ready[owner]=0.
//     - On rsp_ready[owner]: rsp_valid drops the next cycle, ops_done++, go to IDLE.
//     - rsp_ready of the non-owner is ignored.
//   mul_src1/2 hold their last values outside ISSUE/WAIT; mul_en=0 outside ISSUE/WAIT.
//   Latency: accept at cycle 0 -> rsp_valid at cycle MUL_LATENCY+2 (cycle 3 when MUL_LATENCY=1).
//   Throughput: one operation per MUL_LATENCY+3 cycles with rsp_ready held high; no overlap.
//   Simultaneous req_valid: alternate grants; a continuously requesting port never starves the other.
//   New requests are not accepted outside IDLE (req_ready=0).
//   Requester inputs need not stay stable after accept.
//   ops_done wraps from all-ones to 0 without a flag.
//   reset asserted in any state: immediate return to IDLE with reset values; the in-flight op is dropped.
// TESTING
//   1) req0: A=3, B=5, rsp_ready=1
//      -> rsp_valid[0] at cycle 3, rsp_data=0x0000000F, ops_done=1.
//   2) req1: A=0x00010003, B=0x00020005
//      -> p1=15, p2=6, p3=5, rsp_data=0x000B000F on rsp_valid[1].
//   3) A=B=0xFFFFFFFF -> rsp_data=0x00000001.
//      A=B=0x00010000 -> rsp_data=0x00000000 (wrap).
//   4) Both req_valid held high for 4 ops, rsp_ready=1
//      -> grants 0,1,0,1; each rsp_valid goes to the correct port.
//   5) rsp_ready low for 10 cycles in RESP
//      -> rsp_valid and rsp_data stable, req_ready=0, mul_en=0; completes on release.
//   6) reset pulsed during WAIT (MUL_LATENCY=3)
//      -> all outputs 0 the same cycle, no response issued, next request served normally.

Source files
------------

// File: rtl/generic_flash_access_nios2_cpu_mult_seq.sv
// Round-robin sequencer for a 3-cell 16x16 partial-product multiplier; returns low 32 bits of a*b.
// Accept->rsp_valid in MUL_LATENCY+2 cycles; one op in flight, rsp_valid/rsp_data held until rsp_ready[owner].
module generic_flash_access_nios2_cpu_mult_seq #(
    parameter int MUL_LATENCY = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [63:0]      req_a,
    input  logic [63:0]      req_b,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [31:0]      mul_src1,
    output logic [31:0]      mul_src2,
    output logic             mul_en,
    input  logic [31:0]      mul_p1,
    input  logic [31:0]      mul_p2,
    input  logic [31:0]      mul_p3,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_COMBINE,
        S_RESP
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             owner_q;
    logic             prio_q;
    logic [2:0]       cnt_q;
    logic [31:0]      src1_q;
    logic [31:0]      src2_q;
    logic [31:0]      rsp_data_q;
    logic [CNT_W-1:0] ops_q;
    logic [1:0]       grant;
    logic             grant_id;
    logic             rsp_fire;

    // prio_q names the favoured requester; after a grant it points past the winner.
    always_comb begin
        grant = 2'b00;
        if (state_q == S_IDLE && !reset) begin
            if (req_valid[prio_q]) begin
                grant[prio_q] = 1'b1;
            end else if (req_valid[~prio_q]) begin
                grant[~prio_q] = 1'b1;
            end
        end
    end

    assign grant_id = grant[1];
    assign rsp_fire = (state_q == S_RESP) && rsp_ready[owner_q];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (|grant) state_d = S_ISSUE;
            S_ISSUE:   state_d = (MUL_LATENCY == 1) ? S_COMBINE : S_WAIT;
            S_WAIT:    if (cnt_q == 3'd1) state_d = S_COMBINE;
            S_COMBINE: state_d = S_RESP;
            S_RESP:    if (rsp_fire) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            prio_q     <= 1'b0;
            cnt_q      <= 3'd0;
            src1_q     <= 32'd0;
            src2_q     <= 32'd0;
            rsp_data_q <= 32'd0;
            ops_q      <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (|grant) begin
                        src1_q  <= grant_id ? req_a[63:32] : req_a[31:0];
                        src2_q  <= grant_id ? req_b[63:32] : req_b[31:0];
                        owner_q <= grant_id;
                        prio_q  <= ~grant_id;
                    end
                end
                S_ISSUE: cnt_q <= 3'(MUL_LATENCY - 1);
                S_WAIT:  cnt_q <= cnt_q - 3'd1;
                // Only the low 16 bits of p2+p3 survive the shift; carries past bit 31 drop.
                S_COMBINE: rsp_data_q <= mul_p1 + ((mul_p2 + mul_p3) << 16);
                S_RESP:  if (rsp_fire) ops_q <= ops_q + 1'b1;
                default: ;
            endcase
        end
    end

    assign req_ready = grant;
    assign rsp_valid = (state_q == S_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data  = rsp_data_q;
    assign mul_src1  = src1_q;
    assign mul_src2  = src2_q;
    assign mul_en    = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign busy      = (state_q != S_IDLE);
    assign ops_done  = ops_q;

endmodule

// File: tb/tb_generic_flash_access_nios2_cpu_mult_seq.sv
// Directed bench: one sequencer at MUL_LATENCY=1 and one at MUL_LATENCY=3, each with a behavioural cell.
module tb_generic_flash_access_nios2_cpu_mult_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        reset1, reset3;
    logic [1:0]  req_valid1, req_ready1, rsp_valid1, rsp_ready1;
    logic [1:0]  req_valid3, req_ready3, rsp_valid3, rsp_ready3;
    logic [63:0] req_a1, req_b1, req_a3, req_b3;
    logic [31:0] rsp_data1, src1_1, src2_1, p1_1, p2_1, p3_1;
    logic [31:0] rsp_data3, src1_3, src2_3, p1_3, p2_3, p3_3;
    logic        en1, en3, busy1, busy3;
    logic [15:0] ops1, ops3;

    generic_flash_access_nios2_cpu_mult_seq #(.MUL_LATENCY(1), .CNT_W(16)) u1 (
        .clk(clk), .reset(reset1), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_a(req_a1), .req_b(req_b1), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_data(rsp_data1), .mul_src1(src1_1), .mul_src2(src2_1), .mul_en(en1),
        .mul_p1(p1_1), .mul_p2(p2_1), .mul_p3(p3_1), .busy(busy1), .ops_done(ops1)
    );

    generic_flash_access_nios2_cpu_mult_seq #(.MUL_LATENCY(3), .CNT_W(16)) u3 (
        .clk(clk), .reset(reset3), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_a(req_a3), .req_b(req_b3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_data(rsp_data3), .mul_src1(src1_3), .mul_src2(src2_3), .mul_en(en3),
        .mul_p1(p1_3), .mul_p2(p2_3), .mul_p3(p3_3), .busy(busy3), .ops_done(ops3)
    );

    // Behavioural multiplier cells: MUL_LATENCY enabled register stages of {p1,p2,p3}.
    function automatic logic [95:0] parts(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q1, q2, q3;
        q1 = 32'(a[15:0]) * 32'(b[15:0]);
        q2 = 32'(a[15:0]) * 32'(b[31:16]);
        q3 = 32'(a[31:16]) * 32'(b[15:0]);
        return {q1, q2, q3};
    endfunction

    logic [95:0] pipe1;
    logic [95:0] pipe3 [0:2];
    always @(posedge clk) if (en1) pipe1 <= parts(src1_1, src2_1);
    always @(posedge clk) begin
        if (en3) begin
            pipe3[0] <= parts(src1_3, src2_3);
            pipe3[1] <= pipe3[0];
            pipe3[2] <= pipe3[1];
        end
    end
    assign {p1_1, p2_1, p3_1} = pipe1;
    assign {p1_3, p2_3, p3_3} = pipe3[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] rv(input int inst);
        return (inst == 1) ? rsp_valid1 : rsp_valid3;
    endfunction

    // One operation on a single port with rsp_ready held high; checks handshake, latency and data.
    task automatic op(input int inst, input int port, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input int lat, input string tag);
        int k;
        logic [1:0] oh;
        logic [63:0] va, vb;
        oh = (port == 0) ? 2'b01 : 2'b10;
        va = (port == 0) ? {32'h0, a} : {a, 32'h0};
        vb = (port == 0) ? {32'h0, b} : {b, 32'h0};
        @(negedge clk);
        if (inst == 1) begin
            req_valid1 = oh; req_a1 = va; req_b1 = vb; rsp_ready1 = 2'b11;
        end else begin
            req_valid3 = oh; req_a3 = va; req_b3 = vb; rsp_ready3 = 2'b11;
        end
        #1;
        chk({tag, "_ready"}, (inst == 1) ? req_ready1 : req_ready3, oh);
        @(negedge clk);
        k = 1;
        if (inst == 1) begin
            req_valid1 = 2'b00; req_a1 = ~va; req_b1 = ~vb;
        end else begin
            req_valid3 = 2'b00; req_a3 = ~va; req_b3 = ~vb;
        end
        chk({tag, "_issue_en"}, (inst == 1) ? en1 : en3, 1'b1);
        chk({tag, "_issue_src1"}, (inst == 1) ? src1_1 : src1_3, a);
        while (rv(inst) == 2'b00 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_latency"}, k, lat);
        chk({tag, "_rsp_valid"}, rv(inst), oh);
        chk({tag, "_rsp_data"}, (inst == 1) ? rsp_data1 : rsp_data3, exp);
        @(negedge clk);
        chk({tag, "_rsp_drop"}, rv(inst), 2'b00);
    endtask

    initial begin
        int k;
        int bad;
        logic [1:0] exp_g;

        reset1 = 1'b1; reset3 = 1'b1;
        req_valid1 = 2'b00; req_valid3 = 2'b00;
        rsp_ready1 = 2'b00; rsp_ready3 = 2'b00;
        req_a1 = '0; req_b1 = '0; req_a3 = '0; req_b3 = '0;
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", rsp_valid1, 2'b00);
        chk("rst_req_ready", req_ready1, 2'b00);
        chk("rst_rsp_data", rsp_data1, 32'd0);
        chk("rst_mul_en", en1, 1'b0);
        chk("rst_src1", src1_1, 32'd0);
        chk("rst_busy", busy1, 1'b0);
        chk("rst_ops_done", ops1, 16'd0);
        reset1 = 1'b0; reset3 = 1'b0;

        // Basic, partial-product combine, and wrap cases.
        op(1, 0, 32'd3, 32'd5, 32'h0000_000F, 3, "t1");
        chk("t1_ops_done", ops1, 16'd1);
        op(1, 1, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 3, "t2");
        chk("t2_ops_done", ops1, 16'd2);
        op(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 3, "t3a");
        op(1, 1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 3, "t3b");
        chk("t3_ops_done", ops1, 16'd4);

        // Reset in WAIT drops the op; the next request is served normally.
        op(3, 1, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 5, "t6pre");
        chk("t6pre_ops_done", ops3, 16'd1);
        @(negedge clk);
        req_valid3 = 2'b01; req_a3 = {32'h0, 32'd100}; req_b3 = {32'h0, 32'd7}; rsp_ready3 = 2'b11;
        @(negedge clk);
        req_valid3 = 2'b00;
        @(negedge clk);
        chk("t6_in_wait_busy", busy3, 1'b1);
        reset3 = 1'b1;
        #1;
        chk("t6_rst_busy", busy3, 1'b0);
        chk("t6_rst_mul_en", en3, 1'b0);
        chk("t6_rst_src1", src1_3, 32'd0);
        chk("t6_rst_src2", src2_3, 32'd0);
        chk("t6_rst_data", rsp_data3, 32'd0);
        chk("t6_rst_ops", ops3, 16'd0);
        chk("t6_rst_rsp_valid", rsp_valid3, 2'b00);
        @(negedge clk);
        reset3 = 1'b0;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid3 != 2'b00) bad++;
        end
        chk("t6_no_rsp_after_rst", bad, 0);
        op(3, 0, 32'd3, 32'd5, 32'h0000_000F, 5, "t6post");
        chk("t6post_ops_done", ops3, 16'd1);

        // Both ports requesting continuously: grants alternate from req0.
        @(negedge clk);
        reset1 = 1'b1;
        #1;
        chk("t4_rst_ops", ops1, 16'd0);
        @(negedge clk);
        reset1 = 1'b0;
        req_a1 = {32'h100, 32'd7}; req_b1 = {32'h100, 32'd9};
        req_valid1 = 2'b11; rsp_ready1 = 2'b11;
        #1;
        for (int n = 0; n < 4; n++) begin
            exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
            k = 0;
            while (req_ready1 == 2'b00 && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk("t4_grant", req_ready1, exp_g);
            k = 0;
            @(negedge clk);
            while (rsp_valid1 == 2'b00 && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk("t4_rsp_port", rsp_valid1, exp_g);
            chk("t4_rsp_data", rsp_data1, (exp_g == 2'b01) ? 32'd63 : 32'h0001_0000);
            @(negedge clk);
        end
        req_valid1 = 2'b00;
        chk("t4_ops_done", ops1, 16'd4);

        // Response backpressure: owner stalls 10 cycles, non-owner ready and request ignored.
        @(negedge clk);
        req_valid1 = 2'b01; req_a1 = {32'h0, 32'h1234}; req_b1 = {32'h0, 32'h10};
        rsp_ready1 = 2'b10;
        @(negedge clk);
        req_valid1 = 2'b10;
        k = 0;
        while (rsp_valid1 == 2'b00 && k < 20) begin
            @(negedge clk);
            k++;
        end
        for (int n = 0; n < 10; n++) begin
            chk("t5_hold_valid", rsp_valid1, 2'b01);
            chk("t5_hold_data", rsp_data1, 32'h0001_2340);
            chk("t5_hold_req_ready", req_ready1, 2'b00);
            chk("t5_hold_mul_en", en1, 1'b0);
            @(negedge clk);
        end
        rsp_ready1 = 2'b11;
        req_valid1 = 2'b00;
        @(negedge clk);
        chk("t5_release_valid", rsp_valid1, 2'b00);
        chk("t5_ops_done", ops1, 16'd5);
        chk("t5_idle", busy1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
